// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer and its digit scanner.
package alu_pkg;

  localparam int unsigned DISP_W     = 7;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned OPERAND_W  = 6;
  localparam int unsigned OPCODE_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_0 = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_1 = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_2 = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_3 = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_4 = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_5 = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_6 = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_7 = 3'd7;

  typedef logic [NUM_DIGITS-1:0][DISP_W-1:0] disp_words_t;

  // Out-of-range indices light no digit rather than aliasing onto a real one.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = {NUM_DIGITS{1'b0}};
    if (idx < 3'(NUM_DIGITS)) begin
      oh[idx] = 1'b1;
    end else begin
      oh = {NUM_DIGITS{1'b0}};
    end
    return oh;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request handshake between the switch/stimulus front end and the sequencer.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand_a;
  logic [OPERAND_W-1:0] operand_b;

  modport master (output req_valid, output opcode, output operand_a, output operand_b,
                  input req_ready);
  modport slave  (input req_valid, input opcode, input operand_a, input operand_b,
                  output req_ready);
endinterface

// File: rtl/digit_scanner.sv
// Free-running time multiplexer: shows each latched word for SCAN_DIV cycles on one segment bus.
module digit_scanner
  import alu_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  disp_words_t           words,
  output logic [DISP_W-1:0]     seg,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int unsigned          DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LOAD = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]           LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_r;
  logic [2:0]       idx_r;

  // Divider and digit index; reset loads a full period so digit 0 gets a whole slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= DIV_LOAD;
      idx_r <= 3'd0;
    end else if (div_r == {DIV_W{1'b0}}) begin
      div_r <= DIV_LOAD;
      idx_r <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
    end else begin
      div_r <= div_r - DIV_W'(1);
    end
  end

  // One-hot enable and segment select for the current digit.
  always_comb begin
    digit_en = digit_onehot(idx_r);
    seg      = {DISP_W{1'b0}};
    if (idx_r <= LAST_IDX) begin
      seg = words[idx_r];
    end else begin
      seg = {DISP_W{1'b0}};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU request, drives the shared datapath, waits SETTLE cycles, latches the six
// display words and hands them to the digit scanner.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  alu_op_sequencer_if.slave            req,
  input  logic                         clear,
  output logic [OPCODE_W-1:0]          op_sel,
  output logic [OPERAND_W-1:0]         op_a,
  output logic [OPERAND_W-1:0]         op_b,
  input  logic [NUM_DIGITS*DISP_W-1:0] disp_in,
  output logic                         done,
  output logic                         busy,
  output logic [DISP_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]        digit_en
);

  localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 accept_s, capture_s, blank_s;
  logic [OPCODE_W-1:0]  op_sel_r;
  logic [OPERAND_W-1:0] op_a_r, op_b_r;
  disp_words_t          disp_r;

  // Next-state logic; clear only blanks while idle so an in-flight capture always wins.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    blank_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        blank_s = clear;
        if (req.req_valid) begin
          accept_s = 1'b1;
          cnt_s    = CNT_LOAD;
          state_s  = ST_SETTLE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_CAPTURE;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        capture_s = 1'b1;
        state_s   = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and settle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request registers hold until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_sel_r <= {OPCODE_W{1'b0}};
      op_a_r   <= {OPERAND_W{1'b0}};
      op_b_r   <= {OPERAND_W{1'b0}};
    end else if (accept_s) begin
      op_sel_r <= req.opcode;
      op_a_r   <= req.operand_a;
      op_b_r   <= req.operand_b;
    end else begin
      op_sel_r <= op_sel_r;
    end
  end

  // Display capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_r <= {(NUM_DIGITS*DISP_W){1'b0}};
    end else if (capture_s) begin
      disp_r <= disp_in;
    end else if (blank_s) begin
      disp_r <= {(NUM_DIGITS*DISP_W){1'b0}};
    end else begin
      disp_r <= disp_r;
    end
  end

  assign req.req_ready = (state_r == ST_IDLE);
  assign busy          = (state_r == ST_SETTLE) || (state_r == ST_CAPTURE);
  assign done          = (state_r == ST_CAPTURE);
  assign op_sel        = op_sel_r;
  assign op_a          = op_a_r;
  assign op_b          = op_b_r;

  digit_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .words    (disp_r),
    .seg      (seg),
    .digit_en (digit_en)
  );

endmodule
